// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: state encodings, opcodes, flag indices and opcode helpers for alu_sequencer
package alu_seq_pkg;
  typedef enum logic [2:0] {S_IDLE, S_LO, S_HI, S_DONE, S_ERR} state_e;
  localparam logic [7:0] OP_AND   = 8'h01;
  localparam logic [7:0] OP_OR    = 8'h02;
  localparam logic [7:0] OP_XOR   = 8'h03;
  localparam logic [7:0] OP_NOT   = 8'h04;
  localparam logic [7:0] OP_ADD   = 8'h05;
  localparam logic [7:0] OP_ADDU  = 8'h06;
  localparam logic [7:0] OP_ADDC  = 8'h07;
  localparam logic [7:0] OP_ADDCU = 8'h08;
  localparam logic [7:0] OP_SUB   = 8'h09;
  localparam logic [7:0] OP_CMP   = 8'h0B;
  localparam logic [7:0] OP_CMPU  = 8'h0F;
  localparam logic [3:0] OPH_ADDI  = 4'h5;
  localparam logic [3:0] OPH_ADDUI = 4'h6;
  localparam logic [3:0] OPH_ADDCI = 4'h7;
  localparam int FLG_Z = 4;
  localparam int FLG_C = 3;
  localparam int FLG_O = 2;
  localparam int FLG_N = 1;
  localparam int FLG_L = 0;
  function automatic logic is_legal(input logic [7:0] op, input logic wide);
    return wide ? op inside {OP_AND, OP_OR, OP_XOR, OP_NOT, OP_ADD, OP_ADDU}
                : op inside {OP_AND, OP_OR, OP_XOR, OP_NOT, OP_ADD, OP_ADDU, OP_ADDC,
                             OP_ADDCU, OP_SUB, OP_CMP, OP_CMPU} ||
                  op[7:4] inside {OPH_ADDI, OPH_ADDUI, OPH_ADDCI};
  endfunction
  // The high half of a wide add must absorb the low-half carry.
  function automatic logic [7:0] hi_opcode(input logic [7:0] op);
    return op == OP_ADD ? OP_ADDC : op == OP_ADDU ? OP_ADDCU : op;
  endfunction
endpackage

// File: rtl/alu_sequencer.sv
// alu_sequencer: multi-cycle controller driving a 16-bit ALU, chaining two passes for 32-bit ops
//   clk, reset_n         clock, async active-low reset
//   Start/Wide/Opcode/A/B request in (sampled only in IDLE)
//   Busy/Done/Error      status; Done/Error are one-cycle pulses
//   Result/Flags         registered result and ZCONL flag register
//   AluA/AluB/AluOpcode/AluCin -> ALU, AluC/AluFlags <- ALU
module alu_sequencer
  import alu_seq_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        Start,
  input  logic        Wide,
  input  logic [7:0]  Opcode,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Busy,
  output logic        Done,
  output logic        Error,
  output logic [31:0] Result,
  output logic [4:0]  Flags,
  output logic [15:0] AluA,
  output logic [15:0] AluB,
  output logic [7:0]  AluOpcode,
  output logic        AluCin,
  input  logic [15:0] AluC,
  input  logic [4:0]  AluFlags
);
  state_e      state_q, state_d;
  logic [31:0] a_q, b_q, result_q;
  logic [7:0]  op_q;
  logic        wide_q, zlo_q, clo_q;
  logic [15:0] lo_q;
  logic [4:0]  flags_q;
  logic        start_ok, in_lo, in_hi;
  assign start_ok = Start && is_legal(Opcode, Wide);
  assign in_lo = state_q == S_LO;
  assign in_hi = state_q == S_HI;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      wide_q   <= 1'b0;
      lo_q     <= '0;
      zlo_q    <= 1'b0;
      clo_q    <= 1'b0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && start_ok) begin
        a_q    <= A;
        b_q    <= B;
        op_q   <= Opcode;
        wide_q <= Wide;
      end
      if (in_lo) begin
        lo_q  <= AluC;
        zlo_q <= AluFlags[FLG_Z];
        clo_q <= AluFlags[FLG_C];
      end
      if (in_lo && !wide_q) begin
        result_q <= {16'h0000, AluC};
        flags_q  <= AluFlags;
      end
      // Wide zero needs both halves zero; the rest describe the full 32-bit value.
      if (in_hi) begin
        result_q <= {AluC, lo_q};
        flags_q  <= {zlo_q & AluFlags[FLG_Z], AluFlags[FLG_C], AluFlags[FLG_O],
                     AluFlags[FLG_N], AluFlags[FLG_L]};
      end
    end
  end
  always_comb begin
    state_d = S_IDLE;
    if (state_q == S_IDLE && Start) state_d = start_ok ? S_LO : S_ERR;
    else if (in_lo) state_d = wide_q ? S_HI : S_DONE;
    else if (in_hi) state_d = S_DONE;
  end
  // ALU inputs come only from registered operands; idle states park them at zero.
  always_comb begin
    Busy      = state_q != S_IDLE;
    Done      = state_q == S_DONE;
    Error     = state_q == S_ERR;
    AluA      = in_lo ? a_q[15:0] : in_hi ? a_q[31:16] : 16'h0000;
    AluB      = in_lo ? b_q[15:0] : in_hi ? b_q[31:16] : 16'h0000;
    AluOpcode = in_lo ? op_q : in_hi ? hi_opcode(op_q) : 8'h00;
    AluCin    = in_lo ? flags_q[FLG_C] : in_hi && clo_q;
  end
  assign Result = result_q;
  assign Flags  = flags_q;
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: scoreboard bench for alu_sequencer with a behavioural 16-bit ALU stand-in
module tb_alu_sequencer;
  logic        clk = 1'b0, reset_n = 1'b0, Start = 1'b0, Wide = 1'b0;
  logic [7:0]  Opcode = 8'h00;
  logic [31:0] A = '0, B = '0;
  logic        Busy, Done, Error, AluCin;
  logic [31:0] Result;
  logic [4:0]  Flags, AluFlags;
  logic [15:0] AluA, AluB, AluC;
  logic [7:0]  AluOpcode;
  logic [36:0] alu_out;
  typedef struct {logic err; logic [31:0] res; logic [4:0] flg; int due;} exp_t;
  exp_t        sb[$];
  int          checks = 0, failures = 0, cyc = 0, n_done = 0, mark;
  logic [31:0] exp_res = '0;
  logic [4:0]  exp_flg = '0;

  always #5 clk = ~clk;

  alu_sequencer dut (
    .clk(clk), .reset_n(reset_n), .Start(Start), .Wide(Wide), .Opcode(Opcode), .A(A), .B(B),
    .Busy(Busy), .Done(Done), .Error(Error), .Result(Result), .Flags(Flags),
    .AluA(AluA), .AluB(AluB), .AluOpcode(AluOpcode), .AluCin(AluCin),
    .AluC(AluC), .AluFlags(AluFlags)
  );

  // Returns {Z,C,O,N,L, result}; w selects a 32-bit or 16-bit word.
  function automatic logic [36:0] calc(input logic [7:0] op, input logic [31:0] a_in,
                                       input logic [31:0] b_in, input logic cin, input logic w);
    logic [31:0] m, a, b, r;
    logic [32:0] s;
    logic        c, o, n, arith, signd;
    int          hb;
    m = w ? 32'hFFFF_FFFF : 32'h0000_FFFF;
    hb = w ? 31 : 15;
    a = a_in & m;
    b = b_in & m;
    s = '0;
    arith = 1'b1;
    signd = op == 8'h05 || op == 8'h07;
    if (op == 8'h01) begin s = {1'b0, a & b}; arith = 1'b0; end
    else if (op == 8'h02) begin s = {1'b0, a | b}; arith = 1'b0; end
    else if (op == 8'h03) begin s = {1'b0, a ^ b}; arith = 1'b0; end
    else if (op == 8'h04) begin s = {1'b0, ~a & m}; arith = 1'b0; end
    else if (op == 8'h05 || op == 8'h06) s = {1'b0, a} + {1'b0, b};
    else if (op == 8'h07 || op == 8'h08) s = {1'b0, a} + {1'b0, b} + {32'h0, cin};
    else if (op[7:4] == 4'h5) s = {1'b0, a} + {29'h0, op[3:0]};
    r = s[31:0] & m;
    c = arith && s[hb+1];
    o = signd && (a[hb] == b[hb]) && (r[hb] != a[hb]);
    n = arith ? (signd && (r[hb] ^ o)) : r[hb];
    return {r == 32'h0, c, o, n, 1'b0, r};
  endfunction

  function automatic logic legal_op(input logic [7:0] op, input logic w);
    if (w) return op >= 8'h01 && op <= 8'h06;
    return (op >= 8'h01 && op <= 8'h09) || op == 8'h0B || op == 8'h0F || (op >= 8'h50 && op <= 8'h7F);
  endfunction

  always_comb alu_out = calc(AluOpcode, {16'h0000, AluA}, {16'h0000, AluB}, AluCin, 1'b0);
  assign AluC = alu_out[15:0];
  assign AluFlags = alu_out[36:32];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (Done) n_done++;
    if (Done || Error) begin
      if (sb.size() == 0) check("unexpected_out", {62'h0, Done, Error}, 64'h0);
      else begin
        e = sb.pop_front();
        check("kind", {62'h0, Done, Error}, e.err ? 64'h1 : 64'h2);
        check("latency", 64'(cyc), 64'(e.due));
        check("result", {32'h0, Result}, {32'h0, e.res});
        check("flags", {59'h0, Flags}, {59'h0, e.flg});
      end
    end
  end

  task automatic issue(input logic w, input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [36:0] r;
    exp_t e;
    int n = 0;
    @(negedge clk);
    while (Busy && n < 20) begin @(negedge clk); n++; end
    if (Busy) check("idle_wait", {63'h0, Busy}, 64'h0);
    Wide = w; Opcode = op; A = a; B = b; Start = 1'b1;
    if (!legal_op(op, w)) e = '{1'b1, exp_res, exp_flg, cyc + 1};
    else begin
      r = calc(op, a, b, exp_flg[3], w);
      exp_res = w ? r[31:0] : {16'h0000, r[15:0]};
      exp_flg = r[36:32];
      e = '{1'b0, exp_res, exp_flg, cyc + (w ? 3 : 2)};
    end
    sb.push_back(e);
    @(negedge clk);
    Start = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 20) begin @(negedge clk); n++; end
    if (sb.size() != 0) begin
      check("drain_timeout", 64'(sb.size()), 64'h0);
      sb.delete();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    #3;
    check("rst_ctl", {46'h0, Busy, Done, Error, Flags, AluOpcode, AluCin}, 64'h0);
    check("rst_result", {32'h0, Result}, 64'h0);
    check("rst_alu_ab", {32'h0, AluA, AluB}, 64'h0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    issue(1'b0, 8'h05, 32'h0000_7FFF, 32'h0000_0001);
    drain();
    check("t1_result", {32'h0, Result}, 64'h0000_8000);
    check("t1_flags", {59'h0, Flags}, 64'b00100);
    issue(1'b1, 8'h05, 32'h0000_FFFF, 32'h0000_0001);
    check("t2_lo_op", {56'h0, AluOpcode}, 64'h05);
    check("t2_lo_a", {48'h0, AluA}, 64'hFFFF);
    @(negedge clk);
    check("t2_hi_op", {56'h0, AluOpcode}, 64'h07);
    check("t2_hi_cin", {63'h0, AluCin}, 64'h1);
    check("t2_hi_a", {48'h0, AluA}, 64'h0);
    drain();
    check("t2_result", {32'h0, Result}, 64'h0001_0000);
    check("t2_zc", {62'h0, Flags[4:3]}, 64'h0);
    issue(1'b1, 8'h06, 32'hFFFF_FFFF, 32'h0000_0001);
    drain();
    check("t3_result", {32'h0, Result}, 64'h0);
    check("t3_zc", {62'h0, Flags[4:3]}, 64'h3);
    issue(1'b1, 8'h09, 32'h1234_5678, 32'h0000_0001);
    drain();
    @(negedge clk);
    check("t4_busy", {63'h0, Busy}, 64'h0);
    check("t4_result", {32'h0, Result}, 64'h0);
    issue(1'b1, 8'h07, 32'h1, 32'h1);
    issue(1'b0, 8'h0A, 32'h1, 32'h1);
    issue(1'b0, 8'h80, 32'h1, 32'h1);
    issue(1'b0, 8'h01, 32'hABCD_F0F0, 32'h1234_FF00);
    issue(1'b0, 8'h03, 32'h0000_AAAA, 32'h0000_5555);
    issue(1'b0, 8'h53, 32'h0000_0010, 32'h0);
    issue(1'b1, 8'h04, 32'h0000_FFFF, 32'h0);
    issue(1'b1, 8'h02, 32'h8000_0001, 32'h0100_0010);
    issue(1'b0, 8'h06, 32'h0000_FFFE, 32'h0000_0003);
    drain();
    mark = n_done;
    issue(1'b1, 8'h05, 32'hFFFF_FFFF, 32'h0000_0001);
    Wide = 1'b0; Opcode = 8'h01; A = 32'h5A5A_5A5A; B = 32'hFFFF_FFFF; Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
    issue(1'b0, 8'h07, 32'h1, 32'h1);
    drain();
    repeat (2) @(negedge clk);
    check("t5_dones", 64'(n_done - mark), 64'h2);
    check("t5_addc", {32'h0, Result}, 64'h3);
    Wide = 1'b1; Opcode = 8'h05; A = 32'h1111_2222; B = 32'h3333_4444; Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
    @(posedge clk);
    #2;
    check("t6_in_hi", {56'h0, AluOpcode}, 64'h07);
    reset_n = 1'b0;
    #1;
    check("t6_rst_ctl", {46'h0, Busy, Done, Error, Flags, AluOpcode, AluCin}, 64'h0);
    check("t6_rst_result", {32'h0, Result}, 64'h0);
    check("t6_rst_alu_ab", {32'h0, AluA, AluB}, 64'h0);
    exp_res = '0;
    exp_flg = '0;
    @(negedge clk);
    reset_n = 1'b1;
    issue(1'b0, 8'h08, 32'h5, 32'h6);
    drain();
    check("t6_after", {32'h0, Result}, 64'hB);
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
